ingress_frame_writer: RTL and testbench

// Memory-side consumer of one ingress CDC port, in clk_mem. Takes each frame the CDC announces, allocates a fixed
// 2 kB packet-buffer slot from an internal free list and writes the 128-bit words into the shared buffer RAM.
// On frame end it emits a descriptor (slot, byte length, VLAN) to the forwarding queue.

---
 rtl/ingress_frame_writer.sv | 216 +++++++++++++++++++++
 tb/tb_ingress_frame_writer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ingress_frame_writer.sv
// ingress_frame_writer: memory-side consumer of one ingress CDC port (clk_mem).
// Allocates a 2 kB buffer slot per frame and writes 128-bit words to the buffer RAM.
// It emits a descriptor at frame end, and drains frames when no slot is free.
// Ports:
//   clk_mem, rst_n (async, active low)
//   mem_frame_ready/bytelen/vlan  - CDC frame-pending handshake
//   mem_frame_start               - 1-cycle pulse that begins streaming
//   mem_valid/mem_data            - frame words
//   mem_frame_done                - 1-cycle pulse after the last word
//   ram_wr_en/addr/data           - buffer RAM write port, addr = {slot, word}
//   desc_valid/ready/buf/bytelen/vlan - descriptor to the forwarding queue
//   buf_free_en/buf_free_idx      - slot returned by egress
//   drop_count                    - saturating count of drained frames
//   free_overflow                 - sticky flag for a return into a full free list
module ingress_frame_writer #(
    parameter  int NUM_BUFS = 32,
    localparam int BUF_BITS = $clog2(NUM_BUFS)
) (
    input  logic                clk_mem,
    input  logic                rst_n,
    input  logic                mem_frame_ready,
    input  logic [10:0]         mem_frame_bytelen,
    input  logic [11:0]         mem_frame_vlan,
    output logic                mem_frame_start,
    input  logic                mem_valid,
    input  logic [127:0]        mem_data,
    input  logic                mem_frame_done,
    output logic                ram_wr_en,
    output logic [BUF_BITS+6:0] ram_wr_addr,
    output logic [127:0]        ram_wr_data,
    output logic                desc_valid,
    input  logic                desc_ready,
    output logic [BUF_BITS-1:0] desc_buf,
    output logic [10:0]         desc_bytelen,
    output logic [11:0]         desc_vlan,
    input  logic                buf_free_en,
    input  logic [BUF_BITS-1:0] buf_free_idx,
    output logic [31:0]         drop_count,
    output logic                free_overflow
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WRITE,
        S_DRAIN,
        S_DESC
    } state_t;

    localparam logic [BUF_BITS:0]   FL_FULL  = (BUF_BITS+1)'(NUM_BUFS);
    localparam logic [BUF_BITS:0]   INIT_END = (BUF_BITS+1)'(NUM_BUFS - 1);
    localparam logic [BUF_BITS:0]   CNT_ONE  = (BUF_BITS+1)'(1);
    localparam logic [BUF_BITS-1:0] PTR_ONE  = BUF_BITS'(1);
    localparam logic [6:0]          OFF_MAX  = 7'd127;

    state_t state_q, state_d;

    logic [BUF_BITS-1:0] fl_mem [NUM_BUFS];
    logic [BUF_BITS-1:0] fl_rd;
    logic [BUF_BITS-1:0] fl_wr;
    logic [BUF_BITS:0]   fl_count;
    logic [BUF_BITS:0]   init_cnt;

    logic                pop;
    logic                push;
    logic                push_ok;
    logic                fl_full;
    logic [BUF_BITS-1:0] push_idx;
    logic                start_d;

    logic [BUF_BITS-1:0] cur_buf;
    logic [6:0]          offset;
    logic [10:0]         len_q;
    logic [11:0]         vlan_q;

    assign fl_full = (fl_count == FL_FULL);
    assign push_ok = push && !fl_full;

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        push     = 1'b0;
        push_idx = buf_free_idx;
        start_d  = 1'b0;
        unique case (state_q)
            S_INIT: begin
                // Free list is seeded with every slot index, one per cycle.
                push     = 1'b1;
                push_idx = init_cnt[BUF_BITS-1:0];
                if (init_cnt == INIT_END) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                push = buf_free_en;
                if (mem_frame_ready) begin
                    start_d = 1'b1;
                    if (fl_count != '0) begin
                        pop     = 1'b1;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_WRITE: begin
                push = buf_free_en;
                if (mem_frame_done) begin
                    state_d = S_DESC;
                end
            end
            S_DRAIN: begin
                push = buf_free_en;
                if (mem_frame_done) begin
                    state_d = S_IDLE;
                end
            end
            S_DESC: begin
                push = buf_free_en;
                if (desc_valid && desc_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk_mem) begin
        if (push_ok) begin
            fl_mem[fl_wr] <= push_idx;
        end
    end

    always_ff @(posedge clk_mem or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_INIT;
            fl_rd           <= '0;
            fl_wr           <= '0;
            fl_count        <= '0;
            init_cnt        <= '0;
            cur_buf         <= '0;
            offset          <= '0;
            len_q           <= '0;
            vlan_q          <= '0;
            mem_frame_start <= 1'b0;
            ram_wr_en       <= 1'b0;
            ram_wr_addr     <= '0;
            ram_wr_data     <= '0;
            desc_valid      <= 1'b0;
            desc_buf        <= '0;
            desc_bytelen    <= '0;
            desc_vlan       <= '0;
            drop_count      <= '0;
            free_overflow   <= 1'b0;
        end else begin
            state_q         <= state_d;
            mem_frame_start <= start_d;
            ram_wr_en       <= 1'b0;

            if (state_q == S_INIT) begin
                init_cnt <= init_cnt + CNT_ONE;
            end

            if (push_ok) begin
                fl_wr <= fl_wr + PTR_ONE;
            end
            if (push && fl_full && state_q != S_INIT) begin
                free_overflow <= 1'b1;
            end
            if (pop) begin
                fl_rd   <= fl_rd + PTR_ONE;
                cur_buf <= fl_mem[fl_rd];
                offset  <= '0;
            end
            unique case ({push_ok, pop})
                2'b10:   fl_count <= fl_count + CNT_ONE;
                2'b01:   fl_count <= fl_count - CNT_ONE;
                default: fl_count <= fl_count;
            endcase

            if (start_d) begin
                len_q  <= mem_frame_bytelen;
                vlan_q <= mem_frame_vlan;
            end

            if (state_q == S_WRITE) begin
                if (mem_valid) begin
                    ram_wr_en   <= 1'b1;
                    ram_wr_addr <= {cur_buf, offset};
                    ram_wr_data <= mem_data;
                    // Oversized frames pile up on the last word of the slot.
                    if (offset != OFF_MAX) begin
                        offset <= offset + 7'd1;
                    end
                end
                if (mem_frame_done) begin
                    desc_valid   <= 1'b1;
                    desc_buf     <= cur_buf;
                    desc_bytelen <= len_q;
                    desc_vlan    <= vlan_q;
                end
            end

            if (state_q == S_DRAIN && mem_frame_done) begin
                if (drop_count != 32'hFFFF_FFFF) begin
                    drop_count <= drop_count + 32'd1;
                end
            end

            if (state_q == S_DESC && desc_ready) begin
                desc_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ingress_frame_writer.sv
// tb_ingress_frame_writer: directed stimulus with scoreboard queues for RAM writes
// and descriptors; a negedge monitor pops and compares.
module tb_ingress_frame_writer;

    logic          clk_mem = 1'b0;
    logic          rst_n;
    logic          mem_frame_ready;
    logic [10:0]   mem_frame_bytelen;
    logic [11:0]   mem_frame_vlan;
    logic          mem_frame_start;
    logic          mem_valid;
    logic [127:0]  mem_data;
    logic          mem_frame_done;
    logic          ram_wr_en;
    logic [11:0]   ram_wr_addr;
    logic [127:0]  ram_wr_data;
    logic          desc_valid;
    logic          desc_ready;
    logic [4:0]    desc_buf;
    logic [10:0]   desc_bytelen;
    logic [11:0]   desc_vlan;
    logic          buf_free_en;
    logic [4:0]    buf_free_idx;
    logic [31:0]   drop_count;
    logic          free_overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0]  addr;
        logic [127:0] data;
    } wr_t;

    typedef struct {
        logic [4:0]  bidx;
        logic [10:0] len;
        logic [11:0] vlan;
    } desc_t;

    wr_t   wr_q[$];
    desc_t desc_q[$];

    ingress_frame_writer #(.NUM_BUFS(32)) dut (
        .clk_mem           (clk_mem),
        .rst_n             (rst_n),
        .mem_frame_ready   (mem_frame_ready),
        .mem_frame_bytelen (mem_frame_bytelen),
        .mem_frame_vlan    (mem_frame_vlan),
        .mem_frame_start   (mem_frame_start),
        .mem_valid         (mem_valid),
        .mem_data          (mem_data),
        .mem_frame_done    (mem_frame_done),
        .ram_wr_en         (ram_wr_en),
        .ram_wr_addr       (ram_wr_addr),
        .ram_wr_data       (ram_wr_data),
        .desc_valid        (desc_valid),
        .desc_ready        (desc_ready),
        .desc_buf          (desc_buf),
        .desc_bytelen      (desc_bytelen),
        .desc_vlan         (desc_vlan),
        .buf_free_en       (buf_free_en),
        .buf_free_idx      (buf_free_idx),
        .drop_count        (drop_count),
        .free_overflow     (free_overflow)
    );

    always #5 clk_mem = ~clk_mem;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Monitor: every RAM write and descriptor handshake is matched in order.
    always @(negedge clk_mem) begin : monitor
        wr_t   ew;
        desc_t ed;
        if (rst_n) begin
            if (ram_wr_en) begin
                checks++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL ram_write: got addr=%h data=%h required none",
                             ram_wr_addr, ram_wr_data);
                end else begin
                    ew = wr_q.pop_front();
                    if (ram_wr_addr !== ew.addr || ram_wr_data !== ew.data) begin
                        errors++;
                        $display("FAIL ram_write: got addr=%h data=%h required addr=%h data=%h",
                                 ram_wr_addr, ram_wr_data, ew.addr, ew.data);
                    end
                end
            end
            if (desc_valid && desc_ready) begin
                checks++;
                if (desc_q.size() == 0) begin
                    errors++;
                    $display("FAIL desc: got buf=%0d len=%0d vlan=%h required none",
                             desc_buf, desc_bytelen, desc_vlan);
                end else begin
                    ed = desc_q.pop_front();
                    if (desc_buf !== ed.bidx || desc_bytelen !== ed.len ||
                        desc_vlan !== ed.vlan) begin
                        errors++;
                        $display("FAIL desc: got buf=%0d len=%0d vlan=%h required buf=%0d len=%0d vlan=%h",
                                 desc_buf, desc_bytelen, desc_vlan, ed.bidx, ed.len, ed.vlan);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_mem);
        #1;
    endtask

    function automatic logic [127:0] word(input int fid, input int i);
        return {16'(fid), 16'(i), 32'hDEAD_BEEF, 32'(fid * 7 + i), 32'h0123_4567};
    endfunction

    task automatic chk_reset_outputs(input string name);
        chk(name, {mem_frame_start, ram_wr_en, ram_wr_addr, ram_wr_data,
                   desc_valid, desc_buf, desc_bytelen, desc_vlan,
                   drop_count, free_overflow}, '0);
    endtask

    task automatic init_no_start(input string name);
        bit bad;
        bad = 1'b0;
        mem_frame_ready   = 1'b1;
        mem_frame_bytelen = 11'd64;
        for (int c = 0; c < 32; c++) begin
            tick();
            if (mem_frame_start) bad = 1'b1;
        end
        chk(name, bad, 1'b0);
    endtask

    task automatic wait_start(output bit got);
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            tick();
            buf_free_en = 1'b0;
            if (mem_frame_start) got = 1'b1;
        end
        chk("start_seen", got, 1'b1);
    endtask

    task automatic send_frame(input int fid, input int len, input int vlan,
                              input int nwords, input int slot, input bit drop,
                              input int hold, input bit free_at_start,
                              input int free_idx);
        bit got;
        bit bad;
        logic [27:0] snap;
        mem_frame_ready   = 1'b1;
        mem_frame_bytelen = 11'(len);
        mem_frame_vlan    = 12'(vlan);
        if (free_at_start) begin
            buf_free_en  = 1'b1;
            buf_free_idx = 5'(free_idx);
        end
        wait_start(got);
        mem_frame_ready = 1'b0;
        if (!got) return;
        for (int i = 0; i < nwords; i++) begin
            mem_valid = 1'b1;
            mem_data  = word(fid, i);
            if (!drop) begin
                wr_q.push_back('{addr: {5'(slot), 7'(i > 127 ? 127 : i)},
                                 data: word(fid, i)});
            end
            tick();
            if (i == 0) chk("start_one_cycle", mem_frame_start, 1'b0);
        end
        mem_valid      = 1'b0;
        mem_frame_done = 1'b1;
        tick();
        mem_frame_done = 1'b0;
        if (drop) begin
            tick();
            chk("drop_no_desc", desc_valid, 1'b0);
        end else begin
            desc_q.push_back('{bidx: 5'(slot), len: 11'(len), vlan: 12'(vlan)});
            for (int c = 0; c < 20 && !desc_valid; c++) tick();
            chk("desc_valid_rise", desc_valid, 1'b1);
            if (hold > 0) begin
                mem_frame_ready   = 1'b1;
                mem_frame_bytelen = 11'd100;
                snap = {desc_buf, desc_bytelen, desc_vlan};
                bad  = 1'b0;
                for (int h = 0; h < hold; h++) begin
                    tick();
                    if (mem_frame_start || !desc_valid ||
                        {desc_buf, desc_bytelen, desc_vlan} != snap) bad = 1'b1;
                end
                chk("desc_hold_stable", bad, 1'b0);
                mem_frame_ready = 1'b0;
            end
            desc_ready = 1'b1;
            tick();
            desc_ready = 1'b0;
            chk("desc_cleared", desc_valid, 1'b0);
        end
        tick();
    endtask

    initial begin
        bit got;
        rst_n             = 1'b0;
        mem_frame_ready   = 1'b0;
        mem_frame_bytelen = '0;
        mem_frame_vlan    = '0;
        mem_valid         = 1'b0;
        mem_data          = '0;
        mem_frame_done    = 1'b0;
        desc_ready        = 1'b0;
        buf_free_en       = 1'b0;
        buf_free_idx      = '0;
        repeat (3) tick();
        chk_reset_outputs("reset_outputs");
        rst_n = 1'b1;

        init_no_start("init_no_start");
        send_frame(1, 64, 12'h00A, 4, 0, 1'b0, 0, 1'b0, 0);
        send_frame(2, 1522, 12'h123, 96, 1, 1'b0, 10, 1'b0, 0);
        for (int f = 3; f <= 32; f++) begin
            send_frame(f, 16, f, 1, f - 1, 1'b0, 0, 1'b0, 0);
        end
        chk("count_all_alloc", dut.fl_count, 6'd0);

        send_frame(33, 32, 12'h033, 2, 0, 1'b1, 0, 1'b0, 0);
        chk("drop_count_1", drop_count, 32'd1);

        buf_free_en  = 1'b1;
        buf_free_idx = 5'd7;
        tick();
        buf_free_en  = 1'b0;
        send_frame(34, 16, 12'h034, 1, 7, 1'b0, 0, 1'b1, 5);
        chk("count_pop_push", dut.fl_count, 6'd1);
        send_frame(35, 16, 12'h035, 1, 5, 1'b0, 0, 1'b0, 0);

        for (int i = 31; i >= 0; i--) begin
            buf_free_en  = 1'b1;
            buf_free_idx = 5'(i);
            tick();
        end
        buf_free_en = 1'b0;
        chk("overflow_before", free_overflow, 1'b0);
        chk("count_full", dut.fl_count, 6'd32);
        buf_free_en  = 1'b1;
        buf_free_idx = 5'd3;
        tick();
        buf_free_en = 1'b0;
        chk("overflow_set", free_overflow, 1'b1);
        chk("count_stays_full", dut.fl_count, 6'd32);

        // Head of the rebuilt-by-frees list is slot 31.
        mem_frame_ready   = 1'b1;
        mem_frame_bytelen = 11'd400;
        mem_frame_vlan    = 12'h0BB;
        wait_start(got);
        mem_frame_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mem_valid = 1'b1;
            mem_data  = word(40, i);
            wr_q.push_back('{addr: {5'd31, 7'(i)}, data: word(40, i)});
            tick();
        end
        mem_valid = 1'b0;
        tick();
        @(negedge clk_mem);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("reset_mid_frame");
        chk("reset_count", dut.fl_count, 6'd0);
        tick();
        rst_n = 1'b1;

        init_no_start("init_again_no_start");
        send_frame(41, 48, 12'h041, 3, 0, 1'b0, 0, 1'b0, 0);

        repeat (3) tick();
        chk("wr_queue_empty", wr_q.size(), 0);
        chk("desc_queue_empty", desc_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
